// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mul_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ITER      = WIDTH_DEF / 2;
  localparam int CNT_W     = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {SEL_ZERO, SEL_P1, SEL_P2, SEL_N2, SEL_N1} booth_sel_e;

  localparam logic [2:0] GRP_Z0 = 3'b000;
  localparam logic [2:0] GRP_P1 = 3'b001;
  localparam logic [2:0] GRP_P1B = 3'b010;
  localparam logic [2:0] GRP_P2 = 3'b011;
  localparam logic [2:0] GRP_N2 = 3'b100;
  localparam logic [2:0] GRP_N1 = 3'b101;
  localparam logic [2:0] GRP_N1B = 3'b110;
  localparam logic [2:0] GRP_Z1 = 3'b111;

  function automatic booth_sel_e booth_decode(input logic [2:0] grp);
    booth_sel_e sel;
    case (grp)
      GRP_P1, GRP_P1B: sel = SEL_P1;
      GRP_P2:          sel = SEL_P2;
      GRP_N2:          sel = SEL_N2;
      GRP_N1, GRP_N1B: sel = SEL_N1;
      default:         sel = SEL_ZERO;
    endcase
    return sel;
  endfunction
endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: maps one 3-bit group to 0, +-M or +-2M.
module booth_r4_sel
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]           grp,
  input  logic [2*WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0]   pp
);
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  logic signed [PW-1:0] m1;
  logic signed [PW-1:0] m2;

  assign m1 = mcand;
  assign m2 = m1 <<< 1;

  always_comb begin
    pp = '0;
    case (booth_decode(grp))
      SEL_P1:  pp = m1;
      SEL_P2:  pp = m2;
      SEL_N2:  pp = ~m2 + ONE;
      SEL_N1:  pp = ~m1 + ONE;
      default: pp = '0;
    endcase
  end
endmodule

// File: rtl/mul_bt32s_seq.sv
// Iterative signed WIDTHxWIDTH -> 2*WIDTH radix-4 Booth multiplier, one group per cycle.
module mul_bt32s_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy
);
  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e state, state_nx;

  logic signed [PW-1:0] mcand;
  logic signed [PW-1:0] acc;
  logic signed [PW-1:0] acc_nx;
  logic [PW-1:0]        pp;
  logic signed [WIDTH:0] mr;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 accept;

  assign last   = (cnt == CW'(STEPS - 1));
  assign accept = in_valid && in_ready;

  booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
    .grp   (mr[2:0]),
    .mcand (mcand),
    .pp    (pp)
  );

  // Partial product weighted by 4^cnt; wraparound beyond PW bits is intended.
  assign acc_nx = acc + ($signed(pp) <<< {cnt, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    if (flush || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !flush;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      res   <= '0;
    end else if (accept) begin
      mcand <= PW'($signed(op1));
      mr    <= {op2, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (flush && state != IDLE) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      mr  <= mr >>> 2;
      cnt <= cnt + 1'b1;
      if (last) res <= acc_nx;
    end
  end
endmodule
